// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO, driven by a one-tick-per-bit baud strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          baud_rate_signal,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, empty;
  logic [7:0]      head;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Every transition is qualified by the baud tick; the line register only moves on ticks.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (baud_rate_signal && !empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (baud_rate_signal) begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_rate_signal) begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_rate_signal) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_rate_signal) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      bit_cnt_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Datapath storage carries no reset; it is only observed after a valid load.
  always_ff @(posedge clk_in) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: vector table, hand sequences and a line-decoding scoreboard.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       baud_rate_signal = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, tx_busy;
  logic [2:0] fifo_count;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int frames  = 0;
  logic [7:0] sb[$];

  uart_transmitter #(.FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst(rst), .baud_rate_signal(baud_rate_signal),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // One clock cycle: inputs applied at a falling edge, outputs readable at the next falling edge.
  task automatic cyc(input logic tk, input logic v, input logic [7:0] d);
    baud_rate_signal = tk;
    tx_valid         = v;
    tx_data          = d;
    @(negedge clk_in);
    baud_rate_signal = 1'b0;
    tx_valid         = 1'b0;
    tx_data          = 8'($urandom);
  endtask

  task automatic tick_period(input int gap);
    cyc(1'b1, 1'b0, 8'($urandom));
    repeat (gap - 1) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  // Line decoder: reconstructs frames from the serial output and checks them against the queue.
  int         m_st = 0;
  int         m_n  = 0;
  logic [7:0] m_b  = 8'h00;
  logic [7:0] m_exp;
  always @(posedge clk_in) begin
    if (rst) begin
      m_st = 0;
    end else if (baud_rate_signal) begin
      #1;
      case (m_st)
        0: if (!uart_tx) begin m_st = 1; m_n = 0; m_b = 8'h00; end
        1: begin
          m_b[m_n] = uart_tx;
          m_n++;
`ifdef UART_TX_PARITY_EN
          if (m_n == 8) m_st = 2;
`else
          if (m_n == 8) m_st = 3;
`endif
        end
        2: begin chk("rx_parity", 32'(uart_tx), 32'(^m_b)); m_st = 3; end
        default: begin
          chk("rx_stop", 32'(uart_tx), 32'd1);
          if (sb.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL rx_unexpected: got byte %0h expected none", m_b);
          end else begin
            m_exp = sb.pop_front();
            chk("rx_byte", 32'(m_b), 32'(m_exp));
          end
          frames++;
          m_st = 0;
        end
      endcase
    end
  end

  typedef struct {
    logic       tk;
    logic       v;
    logic [7:0] d;
    logic       e_tx;
    logic       e_busy;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t       vt[13];
  logic [7:0] bb[3];
  int         f0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd1};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    vt[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    vt[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
`ifdef UART_TX_PARITY_EN
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    vt[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
`else
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    vt[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
`endif
    vt[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;

    // Idle ticks with nothing queued
    for (int i = 0; i < 20; i++) begin
      tick_period(4);
      chk("idle_tx", 32'(uart_tx), 32'd1);
      chk("idle_busy", 32'(tx_busy), 32'd0);
    end
    chk("idle_cnt", 32'(fifo_count), 32'd0);
    chk("idle_ready", 32'(tx_ready), 32'd1);

    // Single 0xA5 frame, one tick every 16 cycles
    for (int i = 0; i < 13; i++) begin
      if (vt[i].v) sb.push_back(vt[i].d);
      cyc(vt[i].tk, vt[i].v, vt[i].d);
      chk($sformatf("a5_tx[%0d]", i), 32'(uart_tx), 32'(vt[i].e_tx));
      chk($sformatf("a5_busy[%0d]", i), 32'(tx_busy), 32'(vt[i].e_busy));
      chk($sformatf("a5_cnt[%0d]", i), 32'(fifo_count), 32'(vt[i].e_cnt));
      repeat (15) cyc(1'b0, 1'b0, 8'($urandom));
    end

    // Push coinciding with a tick: that tick must not start the frame
    sb.push_back(8'hC3);
    cyc(1'b1, 1'b1, 8'hC3);
    chk("pt_tx0", 32'(uart_tx), 32'd1);
    chk("pt_cnt0", 32'(fifo_count), 32'd1);
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
    tick_period(4);
    chk("pt_start", 32'(uart_tx), 32'd0);
    chk("pt_cnt1", 32'(fifo_count), 32'd0);
    repeat (FL) tick_period(4);
    chk("pt_done", 32'(tx_busy), 32'd0);

    // Back-to-back frames, tx_data scrambled after the pushes
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C;
    f0 = frames;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(bb[i]);
      cyc(1'b0, 1'b1, bb[i]);
    end
    chk("b2b_cnt", 32'(fifo_count), 32'd3);
    for (int t = 0; t < 3 * FL; t++) begin
      tick_period(4);
      chk($sformatf("b2b_line[%0d]", t), 32'(uart_tx), 32'(fbit(bb[t / FL], t % FL)));
    end
    tick_period(4);
    chk("b2b_idle", 32'(tx_busy), 32'd0);
    chk("b2b_frames", 32'(frames - f0), 32'd3);

    // FIFO full: overflow push dropped, push at full during pop dropped, push+pop below full
    sb.push_back(8'h11);
    cyc(1'b0, 1'b1, 8'h11);
    tick_period(4);
    chk("full_inflight", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_ready[%0d]", i), 32'(tx_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) sb.push_back(8'(8'h21 + i));
      cyc(1'b0, 1'b1, 8'(8'h21 + i));
    end
    chk("full_cnt", 32'(fifo_count), 32'd4);
    repeat (FL - 1) tick_period(4);
    chk("full_ready_pop", 32'(tx_ready), 32'd0);
    cyc(1'b1, 1'b1, 8'h26);
    chk("full_pushpop_cnt", 32'(fifo_count), 32'd3);
    chk("full_b2b_start", 32'(uart_tx), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
    repeat (FL - 1) tick_period(4);
    chk("pp_ready", 32'(tx_ready), 32'd1);
    sb.push_back(8'h27);
    cyc(1'b1, 1'b1, 8'h27);
    chk("pp_cnt", 32'(fifo_count), 32'd3);
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
    repeat (4 * FL + 2) tick_period(4);
    chk("full_drain_sb", 32'(sb.size()), 32'd0);
    chk("full_drain_cnt", 32'(fifo_count), 32'd0);
    chk("full_drain_busy", 32'(tx_busy), 32'd0);

    // Reset on the 4th tick of a 0x55 frame with more bytes queued
    f0 = frames;
    sb.push_back(8'h55); cyc(1'b0, 1'b1, 8'h55);
    sb.push_back(8'h66); cyc(1'b0, 1'b1, 8'h66);
    sb.push_back(8'h77); cyc(1'b0, 1'b1, 8'h77);
    repeat (3) tick_period(4);
    chk("mr_busy_pre", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    sb.delete();
    chk("mr_tx", 32'(uart_tx), 32'd1);
    chk("mr_cnt", 32'(fifo_count), 32'd0);
    chk("mr_busy", 32'(tx_busy), 32'd0);
    chk("mr_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick_period(4);
      chk("mr_line", 32'(uart_tx), 32'd1);
    end
    chk("mr_frames", 32'(frames - f0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
